pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed ID/EX pipeline register, for reuse at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data payload and a control-bit vector across one stage.
- Uses a valid/ready handshake with an optional skid entry, so back-pressure does not need a combinational ready path.
- Supports flush (bubble insertion) for branch/hazard squash, plus a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 128, payload width (e.g. pc, rs1_data, rs2_data, imm).
- CTRL_W, 16, control-bit width (reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg, branch, rs/rd fields, ...).
- BUBBLE_CTRL, {CTRL_W{1'b0}}, control value presented when the stage holds no valid entry.
- SKID, 1: 1 = two-entry (main + skid), fully registered in_ready; 0 = single entry, in_ready combinational.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  upstream has an entry.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bits.
- flush  input  1  squash all held entries and any entry offered this cycle.
- out_valid  output  1  stage presents an entry.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  payload of the head entry.
- out_ctrl  output  CTRL_W  control of the head entry; BUBBLE_CTRL whenever out_valid=0.
- occupancy  output  2  entries held: 0, 1 or 2 (2 only when SKID=1).
- stall_cycles  output  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- stall_clr  input  1  synchronous clear of stall_cycles.

Behaviour:
- Reset (reset=0, asynchronous):
  - main and skid valid flags = 0.
  - out_data = 0 and out_ctrl = BUBBLE_CTRL.
  - occupancy = 0 and stall_cycles = 0.
  - in_ready = 1 for SKID=1; for SKID=0 it is 1 because out_valid=0.
  - Reset mid-transfer discards all entries immediately.
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- Latency: an accepted entry appears on out_* the next cycle when the stage was empty or the head is being drained.
- out_data and out_ctrl come directly from the main register; no combinational path from in_* to out_*.
- SKID=1, in_ready = ~skid_valid (registered). Next state:
  - main empty or out_xfer, skid empty: in_xfer loads main; otherwise main_valid <= 0 on out_xfer.
  - main full, no out_xfer, in_xfer: entry goes to skid, skid_valid <= 1.
  - out_xfer with skid full: skid moves to main, skid_valid <= 0. in_ready was 0, so no simultaneous load.
  - Ordering is strictly FIFO; no entry is lost or duplicated.
- SKID=0:
  - in_ready = ~out_valid | out_ready.
  - in_xfer loads main; out_xfer without in_xfer clears main_valid.
- Flush (highest priority below reset):
  - Next edge: main_valid = skid_valid = 0.
  - An entry accepted in the flush cycle is discarded.
  - in_ready behaves normally during the flush cycle.
  - out_data holds its last value; out_ctrl switches to BUBBLE_CTRL.
- Data/ctrl regs load only on a load event; while stalled they hold, matching the stall semantics of the fixed register.
- occupancy = main_valid + skid_valid.
- stall_cycles:
  - Increments on each cycle with out_valid & ~out_ready; saturates at all-ones.
  - stall_clr forces 0 and wins over increment.
  - Flush does not clear the counter.

Test Plan:
- Reset then single entry: reset=0 for 2 cycles, release, in_data=32'h00000010 padded, in_ctrl=16'h00A5, 1 cycle valid, out_ready=1 -> out_valid=1 for exactly one cycle after, out_ctrl=16'h00A5, afterwards out_ctrl=BUBBLE_CTRL.
- Back-pressure/skid (SKID=1): out_ready=0, push entries A=DEADBEEF and B=12345678 -> occupancy=2, in_ready=0, out_data=A held; raise out_ready -> A then B on consecutive cycles, in_ready=1 one cycle after A leaves.
- Flush with full stage: occupancy=2, assert flush with in_valid=1 (C) -> next cycle occupancy=0, out_valid=0, out_ctrl=BUBBLE_CTRL, and C never appears.
- Streaming at full rate: in_valid=out_ready=1 for 8 entries 0..7 -> outputs 0..7 in order, one per cycle, occupancy stays 1, stall_cycles=0.
- Stall counter with STALL_CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15 (saturated); pulse stall_clr -> 0.
- SKID=0 build: out_ready=0 with main full -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> simultaneous drain and load, occupancy stays 1.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Valid/ready handshake bundle for one pipeline stage boundary.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int DATA_W      = 128,
    parameter int CTRL_W      = 16,
    parameter int STALL_CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic [CTRL_W-1:0]      in_ctrl;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [CTRL_W-1:0]      out_ctrl;
    logic [1:0]             occupancy;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic                   stall_clr;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready, stall_clr,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cycles
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready, stall_clr,
        output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised pipeline register with optional skid entry,
//               flush and saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter bit                SKID        = 1'b1,
    parameter int                STALL_CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    pipe_stage_reg_if.slave bus
);

    localparam logic [STALL_CNT_W-1:0] c_stall_one = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic                   r_main_valid;
    logic [DATA_W-1:0]      r_main_data;
    logic [CTRL_W-1:0]      r_main_ctrl;
    logic                   r_skid_valid;
    logic [DATA_W-1:0]      r_skid_data;
    logic [CTRL_W-1:0]      r_skid_ctrl;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_in_ready;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_main_take;
    logic w_skid_take;
    logic w_skid_pop;

    assign w_out_xfer = r_main_valid & bus.out_ready;
    assign w_in_xfer  = bus.in_valid & w_in_ready;

    generate
        if (SKID) begin : g_skid
            // in_ready depends only on state; an accepted entry implies skid is empty
            assign w_in_ready  = ~r_skid_valid;
            assign w_main_take = w_in_xfer & (~r_main_valid | w_out_xfer);
            assign w_skid_take = w_in_xfer & r_main_valid & ~w_out_xfer;
            assign w_skid_pop  = w_out_xfer & r_skid_valid;
        end else begin : g_noskid
            assign w_in_ready  = ~r_main_valid | bus.out_ready;
            assign w_main_take = w_in_xfer;
            assign w_skid_take = 1'b0;
            assign w_skid_pop  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (bus.flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_main_take | w_skid_pop) begin
                r_main_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_main_valid <= 1'b0;
            end
            if (w_skid_take) begin
                r_skid_valid <= 1'b1;
            end else if (w_skid_pop) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    // Payload registers only move on a load; flush leaves the last payload visible
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_data <= '0;
            r_main_ctrl <= BUBBLE_CTRL;
            r_skid_data <= '0;
            r_skid_ctrl <= BUBBLE_CTRL;
        end else if (!bus.flush) begin
            if (w_skid_pop) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end else if (w_main_take) begin
                r_main_data <= bus.in_data;
                r_main_ctrl <= bus.in_ctrl;
            end
            if (w_skid_take) begin
                r_skid_data <= bus.in_data;
                r_skid_ctrl <= bus.in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (bus.stall_clr) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid & ~bus.out_ready & ~(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + c_stall_one;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_main_valid;
    assign bus.out_data     = r_main_data;
    assign bus.out_ctrl     = r_main_valid ? r_main_ctrl : BUBBLE_CTRL;
    assign bus.occupancy    = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign bus.stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Drives a SKID=1 and a SKID=0 stage with identical directed
//               stimulus and checks both against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          DW     = 128;
    localparam int          CW     = 16;
    localparam int          SW     = 4;
    localparam logic [15:0] BUBBLE = 16'h8001;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(SW)) bus [2] ();

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        pipe_stage_reg #(
            .DATA_W      (DW),
            .CTRL_W      (CW),
            .BUBBLE_CTRL (BUBBLE),
            .SKID        (gi == 0),
            .STALL_CNT_W (SW)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue model: index 0 may hold two entries, index 1 only one
    for (genvar gi = 0; gi < 2; gi++) begin : g_chk
        logic [DW+CW-1:0] mq [$];
        logic [DW-1:0]    m_hold;
        int               m_stall;

        initial begin
            m_hold  = '0;
            m_stall = 0;
        end

        always @(negedge clk) begin
            logic e_valid;
            logic e_rdy;
            logic in_x;
            logic out_x;
            if (!reset) begin
                mq.delete();
                m_hold  = '0;
                m_stall = 0;
            end
            e_valid = (mq.size() > 0);
            e_rdy   = (gi == 0) ? (mq.size() < 2) : (mq.size() == 0 || bus[gi].out_ready);
            check($sformatf("d%0d out_valid", gi), 128'(bus[gi].out_valid), 128'(e_valid));
            check($sformatf("d%0d in_ready", gi), 128'(bus[gi].in_ready), 128'(e_rdy));
            check($sformatf("d%0d occupancy", gi), 128'(bus[gi].occupancy), 128'(mq.size()));
            check($sformatf("d%0d out_data", gi), bus[gi].out_data,
                  e_valid ? 128'(mq[0][DW+CW-1:CW]) : m_hold);
            check($sformatf("d%0d out_ctrl", gi), 128'(bus[gi].out_ctrl),
                  e_valid ? 128'(mq[0][CW-1:0]) : 128'(BUBBLE));
            check($sformatf("d%0d stall_cycles", gi), 128'(bus[gi].stall_cycles), 128'(m_stall));
            if (reset) begin
                in_x  = bus[gi].in_valid && e_rdy;
                out_x = e_valid && bus[gi].out_ready;
                if (bus[gi].stall_clr) m_stall = 0;
                else if (e_valid && !bus[gi].out_ready && m_stall < 15) m_stall++;
                if (bus[gi].flush) begin
                    mq.delete();
                end else begin
                    if (out_x) void'(mq.pop_front());
                    if (in_x) mq.push_back({bus[gi].in_data, bus[gi].in_ctrl});
                end
                if (mq.size() > 0) m_hold = mq[0][DW+CW-1:CW];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
        bus[0].in_valid = v; bus[0].in_data = d; bus[0].in_ctrl = c; bus[0].out_ready = ordy;
        bus[1].in_valid = v; bus[1].in_data = d; bus[1].in_ctrl = c; bus[1].out_ready = ordy;
    endtask

    task automatic side(input logic fl, input logic sc);
        bus[0].flush = fl; bus[0].stall_clr = sc;
        bus[1].flush = fl; bus[1].stall_clr = sc;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        side(1'b0, 1'b0);

        // reset state
        @(negedge clk);
        check("rst in_ready", 128'(bus[0].in_ready), 128'd1);
        check("rst occupancy", 128'(bus[0].occupancy), 128'd0);
        check("rst out_ctrl", 128'(bus[0].out_ctrl), 128'(16'h8001));
        step(); step();
        reset = 1'b1;

        // single entry
        drive(1'b1, 128'h10, 16'h00A5, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        check("single out_valid", 128'(bus[0].out_valid), 128'd1);
        check("single out_ctrl", 128'(bus[0].out_ctrl), 128'h00A5);
        check("single out_data", bus[0].out_data, 128'h10);
        step();
        @(negedge clk);
        check("single after valid", 128'(bus[0].out_valid), 128'd0);
        check("single after ctrl", 128'(bus[0].out_ctrl), 128'(16'h8001));

        // back-pressure into skid
        drive(1'b1, 128'hDEADBEEF, 16'h0001, 1'b0);
        step();
        drive(1'b1, 128'h12345678, 16'h0002, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("skid occupancy", 128'(bus[0].occupancy), 128'd2);
        check("skid in_ready", 128'(bus[0].in_ready), 128'd0);
        check("skid head", bus[0].out_data, 128'hDEADBEEF);
        step();
        drive(1'b0, '0, '0, 1'b1);
        step();
        @(negedge clk);
        check("skid second", bus[0].out_data, 128'h12345678);
        check("skid ready back", 128'(bus[0].in_ready), 128'd1);
        step();
        @(negedge clk);
        check("skid drained", 128'(bus[0].out_valid), 128'd0);

        // flush with a full stage and an entry on offer
        drive(1'b1, 128'h111, 16'h0011, 1'b0);
        step();
        drive(1'b1, 128'h222, 16'h0022, 1'b0);
        step();
        drive(1'b1, 128'hCCC, 16'h00CC, 1'b0);
        side(1'b1, 1'b0);
        @(negedge clk);
        check("flush pre occ", 128'(bus[0].occupancy), 128'd2);
        step();
        drive(1'b0, '0, '0, 1'b0);
        side(1'b0, 1'b0);
        @(negedge clk);
        check("flush occ", 128'(bus[0].occupancy), 128'd0);
        check("flush ctrl", 128'(bus[0].out_ctrl), 128'(16'h8001));
        check("flush data hold", bus[0].out_data, 128'h111);
        drive(1'b0, '0, '0, 1'b1);
        repeat (3) step();

        // full-rate streaming
        side(1'b0, 1'b1);
        step();
        side(1'b0, 1'b0);
        drive(1'b1, 128'd0, 16'h0100, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            drive(i < 7, 128'(i + 1), 16'(16'h0100 + i + 1), 1'b1);
            @(negedge clk);
            check("stream data", bus[0].out_data, 128'(i));
            check("stream occ", 128'(bus[0].occupancy), 128'd1);
            check("stream stall", 128'(bus[0].stall_cycles), 128'd0);
        end
        step();

        // stall counter saturation and clear
        drive(1'b1, 128'h55, 16'h0055, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        repeat (20) step();
        @(negedge clk);
        check("stall sat d0", 128'(bus[0].stall_cycles), 128'd15);
        check("stall sat d1", 128'(bus[1].stall_cycles), 128'd15);
        side(1'b0, 1'b1);
        step();
        side(1'b0, 1'b0);
        @(negedge clk);
        check("stall clr", 128'(bus[0].stall_cycles), 128'd0);

        // single-entry build: combinational ready, drain and load together
        drive(1'b1, 128'h77, 16'h0077, 1'b0);
        @(negedge clk);
        check("noskid ready low", 128'(bus[1].in_ready), 128'd0);
        step();
        drive(1'b1, 128'h77, 16'h0077, 1'b1);
        @(negedge clk);
        check("noskid ready high", 128'(bus[1].in_ready), 128'd1);
        step();
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        check("noskid occ", 128'(bus[1].occupancy), 128'd1);
        check("noskid data", bus[1].out_data, 128'h77);
        repeat (2) step();

        // asynchronous reset with entries held
        drive(1'b1, 128'h99, 16'h0099, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        step();
        reset = 1'b0;
        #2;
        check("async rst occ d0", 128'(bus[0].occupancy), 128'd0);
        check("async rst valid d1", 128'(bus[1].out_valid), 128'd0);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
